rfphoenix_vrf_wrarb: RTL and testbench
======================================

RFPHOENIX_VRF_WRARB -- requirements
Module: rfPhoenix_vrf_wrarb

Interface
- REQ-001 SHALL have parameter NREQ, default 3; number of write requesters (2..4).
- REQ-002 SHALL have parameter NLANES, default 16; vector lanes, 32 bits each.
- REQ-003 SHALL have parameter TIDW, default 4; thread-id width.
- REQ-004 SHALL have parameter RSW, default 6; register-spec width (TIDW+RSW = 10 = regfile address width).
- REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
- REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
- REQ-007 SHALL have port hold  input  1  freeze; no grants while 1.
- REQ-008 SHALL have port req  input  NREQ  per-requester write valid.
- REQ-009 SHALL have port rthread  input  NREQ*TIDW  per-requester thread.
- REQ-010 SHALL have port rreg  input  NREQ*RSW  per-requester destination register.
- REQ-011 SHALL have port rmask  input  NREQ*NLANES  per-requester lane mask.
- REQ-012 SHALL have port rdat  input  NREQ*NLANES*32  per-requester vector data.
- REQ-013 SHALL have port gnt  output  NREQ  one-hot accept, combinational, valid-and-ready handshake.
- REQ-014 SHALL have port wr  output  1  regfile write strobe.
- REQ-015 SHALL have ports wthread (TIDW), wa (RSW), wmask (NLANES), wdat (NLANES*32)  output  registered regfile write fields.
- REQ-016 SHALL have ports qthread (TIDW), qreg (RSW)  input  hazard query address.
- REQ-017 SHALL have port qhaz  output  1  query hits an in-flight write.

Function
- REQ-018 SHALL assert at most one gnt bit per cycle; gnt[k]=1 only when req[k]=1 and hold=0 and rst=1.
- REQ-019 SHALL select by round-robin: search starts at (ptr+1) mod NREQ, first requesting index wins.
- REQ-020 SHALL update ptr to granted index on each grant; ptr unchanged on cycles with no grant.
- REQ-021 SHALL treat a transfer as occurring on a rising edge where gnt[k]=1; requester holds fields stable until granted.
- REQ-022 SHALL register granted fields into wthread/wa/wmask/wdat one cycle after grant (latency 1).
- REQ-023 SHALL drive wr=1 the cycle after a grant only if the granted rmask is nonzero; zero-mask requests are accepted and discarded (wr=0).
- REQ-024 SHALL drive wr=0 on every cycle not following a grant; write fields hold last value.
- REQ-025 SHALL maintain two in-flight stages: S1 = current output register, S2 = S1 of the previous cycle, each with valid = wr of that stage.
- REQ-026 SHALL drive qhaz=1 combinationally when {qthread,qreg} equals the address of a valid S1 or S2 entry; covers the regfile's 2-cycle read pipeline.
- REQ-027 SHALL, when hold=1, still advance S1->S2 and clear S1 valid (no new grant), so qhaz decays within 2 cycles.
- REQ-028 SHALL, for NREQ requests all simultaneously active, grant each exactly once per NREQ consecutive grant cycles.
- REQ-029 SHALL allow back-to-back grants to the same requester when it is the only one requesting.
- REQ-030 SHALL not combinationally depend gnt on wr, qhaz or any output register other than ptr.

Reset
- REQ-031 SHALL, while rst=0, force gnt=0, wr=0, qhaz=0, S1/S2 valid=0, ptr=NREQ-1 (so requester 0 has first priority), wthread/wa/wmask/wdat=0.
- REQ-032 SHALL, on reset asserted mid-operation, drop any registered write immediately (wr=0 asynchronously); the dropped request is not re-issued.
- REQ-033 SHALL resume arbitration on the first rising edge after rst returns to 1.

Verification
- REQ-034 Post-reset, req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100; wr=1 cycles 2..7 with matching wthread/wa.
- REQ-035 req[1] only, rthread=2, rreg=5, rmask=16'h00F0, rdat lanes=lane index -> gnt=010 cycle 1, cycle 2 wr=1, wa=5, wmask=16'h00F0, wdat matches.
- REQ-036 req[0] with rmask=0 -> gnt[0]=1, next cycle wr=0, qhaz=0 for that address.
- REQ-037 Grant write thread 3 reg 7; query {3,7} -> qhaz=1 on cycles +1 and +2, 0 on +3; query {3,8} -> qhaz=0 throughout.
- REQ-038 req=3'b011 with hold=1 for 3 cycles -> gnt=0, wr=0; hold released -> gnt=001 then 010.
- REQ-039 rst driven low between grant and output edge -> wr=0 immediately, ptr=2; after release req=3'b110 -> gnt=010 first.

Source files
------------

// File: rtl/rfphoenix_vrf_wrarb.sv
// rfPhoenix vector regfile write arbiter: round-robin grant among NREQ
// writers, one registered write port, two-stage in-flight hazard query.
//
// Ports:
//   clk, rst (async, active-low), hold (freeze grants)
//   req/rthread/rreg/rmask/rdat : per-requester write request fields
//   gnt                         : one-hot combinational accept
//   wr/wthread/wa/wmask/wdat    : registered regfile write port
//   qthread/qreg -> qhaz        : query hits a write still in flight
module rfphoenix_vrf_wrarb #(
    parameter int NREQ   = 3,
    parameter int NLANES = 16,
    parameter int TIDW   = 4,
    parameter int RSW    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*TIDW-1:0]     rthread,
    input  logic [NREQ*RSW-1:0]      rreg,
    input  logic [NREQ*NLANES-1:0]   rmask,
    input  logic [NREQ*NLANES*32-1:0] rdat,
    output logic [NREQ-1:0]          gnt,
    output logic                     wr,
    output logic [TIDW-1:0]          wthread,
    output logic [RSW-1:0]           wa,
    output logic [NLANES-1:0]        wmask,
    output logic [NLANES*32-1:0]     wdat,
    input  logic [TIDW-1:0]          qthread,
    input  logic [RSW-1:0]           qreg,
    output logic                     qhaz
);
    localparam int PW = $clog2(NREQ);
    localparam int AW = TIDW + RSW;

    logic [PW-1:0]          r_ptr;
    logic                   r_wr;
    logic [TIDW-1:0]        r_wthread;
    logic [RSW-1:0]         r_wa;
    logic [NLANES-1:0]      r_wmask;
    logic [NLANES*32-1:0]   r_wdat;
    logic                   r_s2_v;
    logic [AW-1:0]          r_s2_a;

    logic                   w_any;
    logic                   w_fire;
    logic [PW-1:0]          w_gidx;
    int                     w_idx;
    logic [AW-1:0]          w_qa;

    // Walk offsets from farthest to nearest so the nearest requester
    // after ptr is the last (winning) assignment.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_idx  = 0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = (int'(r_ptr) + i) % NREQ;
            if (req[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = PW'(w_idx);
            end
        end
    end

    assign w_fire = w_any & ~hold & rst;
    assign gnt    = w_fire ? (NREQ'(1) << w_gidx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= PW'(NREQ - 1);
            r_wr      <= 1'b0;
            r_wthread <= '0;
            r_wa      <= '0;
            r_wmask   <= '0;
            r_wdat    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_a    <= '0;
        end else begin
            r_s2_v <= r_wr;
            r_s2_a <= {r_wthread, r_wa};
            // Zero-mask requests are accepted but never strobe the regfile.
            r_wr   <= w_fire & (|rmask[w_gidx*NLANES +: NLANES]);
            if (w_fire) begin
                r_ptr     <= w_gidx;
                r_wthread <= rthread[w_gidx*TIDW +: TIDW];
                r_wa      <= rreg[w_gidx*RSW +: RSW];
                r_wmask   <= rmask[w_gidx*NLANES +: NLANES];
                r_wdat    <= rdat[w_gidx*NLANES*32 +: NLANES*32];
            end
        end
    end

    assign w_qa = {qthread, qreg};
    assign qhaz = (r_wr && ({r_wthread, r_wa} == w_qa)) ||
                  (r_s2_v && (r_s2_a == w_qa));

    assign wr      = r_wr;
    assign wthread = r_wthread;
    assign wa      = r_wa;
    assign wmask   = r_wmask;
    assign wdat    = r_wdat;
endmodule

// File: tb/tb_rfphoenix_vrf_wrarb.sv
// Bench for rfphoenix_vrf_wrarb: directed vectors plus a per-cycle
// comparison against a write-log model of the arbiter.
module tb_rfphoenix_vrf_wrarb;
    localparam int NREQ = 3;
    localparam int NL   = 16;
    localparam int TW   = 4;
    localparam int RW   = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  hold;
    logic [NREQ-1:0]       req;
    logic [NREQ*TW-1:0]    rthread;
    logic [NREQ*RW-1:0]    rreg;
    logic [NREQ*NL-1:0]    rmask;
    logic [NREQ*NL*32-1:0] rdat;
    logic [NREQ-1:0]       gnt;
    logic                  wr;
    logic [TW-1:0]         wthread;
    logic [RW-1:0]         wa;
    logic [NL-1:0]         wmask;
    logic [NL*32-1:0]      wdat;
    logic [TW-1:0]         qthread;
    logic [RW-1:0]         qreg;
    logic                  qhaz;

    int n_vec = 0;
    int n_err = 0;
    bit run   = 1'b1;

    rfphoenix_vrf_wrarb #(
        .NREQ(NREQ), .NLANES(NL), .TIDW(TW), .RSW(RW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req(req), .rthread(rthread), .rreg(rreg),
        .rmask(rmask), .rdat(rdat),
        .gnt(gnt), .wr(wr), .wthread(wthread), .wa(wa),
        .wmask(wmask), .wdat(wdat),
        .qthread(qthread), .qreg(qreg), .qhaz(qhaz)
    );

    always #5 clk = ~clk;

    // ---- model: pointer, last write fields, log of issued writes ----
    typedef struct {
        int          c;
        logic [9:0]  a;
    } wlog_t;

    wlog_t           wlog[$];
    int              cyc  = 0;
    int              m_ptr = NREQ - 1;
    bit              m_wr = 1'b0;
    logic [TW-1:0]   m_th = '0;
    logic [RW-1:0]   m_ra = '0;
    logic [NL-1:0]   m_mk = '0;
    logic [NL*32-1:0] m_dt = '0;
    int              m_k;
    wlog_t           m_e;

    function automatic int pick(logic [NREQ-1:0] r, int p);
        for (int i = 1; i <= NREQ; i++) begin
            int ix;
            ix = (p + i) % NREQ;
            if (r[ix]) return ix;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr = NREQ - 1;
            m_wr  = 1'b0;
            m_th  = '0;
            m_ra  = '0;
            m_mk  = '0;
            m_dt  = '0;
            wlog.delete();
        end else begin
            cyc++;
            m_k = hold ? -1 : pick(req, m_ptr);
            m_wr = 1'b0;
            if (m_k >= 0) begin
                m_ptr = m_k;
                m_th  = rthread[m_k*TW +: TW];
                m_ra  = rreg[m_k*RW +: RW];
                m_mk  = rmask[m_k*NL +: NL];
                m_dt  = rdat[m_k*NL*32 +: NL*32];
                m_wr  = (m_mk != '0);
                if (m_wr) begin
                    m_e.c = cyc;
                    m_e.a = {m_th, m_ra};
                    wlog.push_back(m_e);
                end
            end
        end
    end

    // ---- per-cycle compare against the model ----
    logic [NREQ-1:0] x_g;
    bit              x_q;
    int              x_k;

    always @(negedge clk) begin
        if (run) begin
            x_k = pick(req, m_ptr);
            x_g = (rst && !hold && x_k >= 0) ? NREQ'(1 << x_k) : '0;
            x_q = 1'b0;
            foreach (wlog[i])
                if (cyc - wlog[i].c < 2 && wlog[i].a == {qthread, qreg})
                    x_q = 1'b1;
            n_vec++;
            if (gnt !== x_g || wr !== m_wr || qhaz !== x_q ||
                wthread !== m_th || wa !== m_ra ||
                wmask !== m_mk || wdat !== m_dt) begin
                n_err++;
                $display("FAIL model t=%0t gnt %b/%b wr %b/%b qhaz %b/%b th %0d/%0d wa %0d/%0d mk %h/%h dat_ok %0b",
                         $time, gnt, x_g, wr, m_wr, qhaz, x_q,
                         wthread, m_th, wa, m_ra, wmask, m_mk,
                         wdat === m_dt);
            end
        end
    end

    // ---- directed stimulus with literal expectations ----
    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input int th, input int rg,
                           input logic [NL-1:0] m, input int base);
        rthread[k*TW +: TW] = TW'(th);
        rreg[k*RW +: RW]    = RW'(rg);
        rmask[k*NL +: NL]   = m;
        for (int j = 0; j < NL; j++)
            rdat[(k*NL+j)*32 +: 32] = 32'(base + j);
    endtask

    logic [NL*32-1:0] lanes;

    initial begin
        rst = 1'b0; hold = 1'b0; req = '1;
        rthread = '0; rreg = '0; rmask = '0; rdat = '0;
        qthread = '0; qreg = '0;
        for (int k = 0; k < NREQ; k++)
            set_req(k, k + 1, k + 10, NL'(1) << k, k * 100);
        smp;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_qhaz", 32'(qhaz), 0);
        chk("rst_wa", 32'(wa), 0);

        // all three requesting: strict rotation from requester 0
        step; rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step;
            smp;
            chk("rr_gnt", 32'(gnt), 32'(1 << (i % 3)));
            if (i > 0) begin
                chk("rr_wr", 32'(wr), 1);
                chk("rr_wa", 32'(wa), 32'(10 + (i - 1) % 3));
                chk("rr_th", 32'(wthread), 32'(1 + (i - 1) % 3));
            end
        end
        step; req = '0;
        smp;
        chk("rr_last_wa", 32'(wa), 12);
        chk("rr_last_wr", 32'(wr), 1);

        // single requester 1, lanes carry their index
        step; req = 3'b010; set_req(1, 2, 5, 16'h00F0, 0);
        smp;
        chk("one_gnt", 32'(gnt), 32'b010);
        step; req = '0;
        smp;
        chk("one_wr", 32'(wr), 1);
        chk("one_wa", 32'(wa), 5);
        chk("one_th", 32'(wthread), 2);
        chk("one_mask", 32'(wmask), 32'h00F0);
        for (int j = 0; j < NL; j++) lanes[j*32 +: 32] = 32'(j);
        n_vec++;
        if (wdat !== lanes) begin
            n_err++;
            $display("FAIL one_wdat lane0 got %h want %h",
                     wdat[31:0], lanes[31:0]);
        end

        // back-to-back grants to a lone requester
        step; req = 3'b010;
        smp; chk("b2b_gnt0", 32'(gnt), 32'b010);
        step;
        smp; chk("b2b_gnt1", 32'(gnt), 32'b010);

        // zero-mask request: accepted, no write, no hazard
        step; req = 3'b001; set_req(0, 1, 3, '0, 0);
        qthread = 4'd1; qreg = 6'd3;
        smp; chk("z_gnt", 32'(gnt), 32'b001);
        step; req = '0;
        smp;
        chk("z_wr", 32'(wr), 0);
        chk("z_qhaz", 32'(qhaz), 0);

        // hazard window of a write to {3,7}
        step; req = 3'b001; set_req(0, 3, 7, 16'hFFFF, 50);
        qthread = 4'd3; qreg = 6'd7;
        smp; chk("hz_q0", 32'(qhaz), 0);
        step; req = '0;
        smp; chk("hz_q1", 32'(qhaz), 1);
        step;
        smp; chk("hz_q2", 32'(qhaz), 1);
        step;
        smp; chk("hz_q3", 32'(qhaz), 0);
        step; req = 3'b001; qreg = 6'd8;
        smp; chk("hz_n0", 32'(qhaz), 0);
        step; req = '0;
        smp; chk("hz_n1", 32'(qhaz), 0);
        step;
        smp; chk("hz_n2", 32'(qhaz), 0);

        // hold: no grants, in-flight hazard decays, then rotation resumes
        step; req = 3'b100; set_req(2, 0, 9, 16'h0001, 7);
        qthread = 4'd0; qreg = 6'd9;
        smp; chk("h_pre", 32'(gnt), 32'b100);
        step; req = 3'b011; hold = 1'b1;
        smp;
        chk("h_gnt0", 32'(gnt), 0);
        chk("h_q0", 32'(qhaz), 1);
        step;
        smp;
        chk("h_gnt1", 32'(gnt), 0);
        chk("h_wr1", 32'(wr), 0);
        chk("h_q1", 32'(qhaz), 1);
        step;
        smp;
        chk("h_gnt2", 32'(gnt), 0);
        chk("h_q2", 32'(qhaz), 0);
        step; hold = 1'b0;
        smp; chk("h_rel0", 32'(gnt), 32'b001);
        step;
        smp; chk("h_rel1", 32'(gnt), 32'b010);

        // reset between grant edge and the write it produced
        step; req = 3'b001;
        smp; chk("r_gnt", 32'(gnt), 32'b001);
        step; req = '0;
        chk("r_wr_pre", 32'(wr), 1);
        rst = 1'b0;
        #1;
        chk("r_wr_drop", 32'(wr), 0);
        smp;
        step; rst = 1'b1; req = 3'b110;
        smp; chk("r_first", 32'(gnt), 32'b010);
        step;
        smp;
        chk("r_second", 32'(gnt), 32'b100);
        chk("r_wr", 32'(wr), 1);
        step; req = '0;
        smp;
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
